// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle RV32I controller: FSM state
// encoding, opcode constants, ALU operation codes and datapath mux selects.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMREAD,
    S_MEMWB,
    S_MEMWRITE,
    S_EXECUTER,
    S_EXECUTEI,
    S_ALUWB,
    S_BEQ
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_ADDI = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  localparam logic       ADR_PC     = 1'b0;
  localparam logic       ADR_ALUOUT = 1'b1;

  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_READDATA  = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;

  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;

  // Immediate format depends only on the opcode; everything without an
  // S or B immediate uses the I format.
  function automatic logic [1:0] imm_src(input logic [6:0] op);
    case (op)
      OP_SW:   imm_src = IMM_S;
      OP_BEQ:  imm_src = IMM_B;
      default: imm_src = IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decoder shared with the single-cycle core.
//   Op      in  7  opcode (Instr[6:0])
//   funct3  in  3  Instr[14:12]
//   funct7  in  7  Instr[31:25]
//   ALUctrl out 3  ALU operation
module alu_decoder
  import cpu_pkg::*;
(
  input  logic [6:0] Op,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  output logic [2:0] ALUctrl
);

  logic unused_funct7;
  assign unused_funct7 = ^{funct7[6], funct7[4:0]};

  always_comb begin
    ALUctrl = ALU_ADD;
    case (funct3)
      // addi has Op[5]=0, so immediate bit 30 never turns it into a subtract
      3'b000:  ALUctrl = (Op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
      3'b010:  ALUctrl = ALU_SLT;
      3'b110:  ALUctrl = ALU_OR;
      3'b111:  ALUctrl = ALU_AND;
      default: ALUctrl = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Sequencing FSM for the shared-memory multi-cycle RV32I datapath.
// Inputs: clk, rst (sync, active high), Instr (IR contents), EQ (ALU zero),
// MemReady (memory access completes this cycle).
// Outputs: memory handshake (MemReq, MemWrite, AdrSrc), register enables
// (IRWrite, PCWrite, RegWrite), mux selects (ResultSrc, ALUSrcA, ALUSrcB,
// ImmSrc), ALUctrl, and the InstrDone / Illegal status pulses.
//
// state      | meaning
// FETCH      | read instruction at PC, PC+4 into PC
// DECODE     | dispatch on opcode, branch target into ALUOut
// MEMADR     | rs1 + imm into ALUOut
// MEMREAD    | read data memory at ALUOut
// MEMWB      | write read data to rd
// MEMWRITE   | write rs2 to memory at ALUOut
// EXECUTER   | rs1 op rs2
// EXECUTEI   | rs1 op imm
// ALUWB      | write ALUOut to rd
// BEQ        | compare rs1/rs2, take branch from ALUOut if equal
module multicycle_control
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] Instr,
  input  logic        EQ,
  input  logic        MemReady,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        AdrSrc,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        RegWrite,
  output logic [1:0]  ResultSrc,
  output logic [1:0]  ALUSrcA,
  output logic [1:0]  ALUSrcB,
  output logic [1:0]  ImmSrc,
  output logic [2:0]  ALUctrl,
  output logic        InstrDone,
  output logic        Illegal
);

  state_t     state, state_nxt;
  logic [6:0] op;
  logic [2:0] alu_dec;

  logic unused_instr;
  assign unused_instr = ^{Instr[24:15], Instr[11:7]};

  assign op = Instr[6:0];

  alu_decoder u_alu_decoder (
    .Op      (op),
    .funct3  (Instr[14:12]),
    .funct7  (Instr[31:25]),
    .ALUctrl (alu_dec)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    MemReq    = 1'b0;
    MemWrite  = 1'b0;
    AdrSrc    = ADR_PC;
    IRWrite   = 1'b0;
    PCWrite   = 1'b0;
    RegWrite  = 1'b0;
    ResultSrc = RES_ALUOUT;
    ALUSrcA   = SRCA_PC;
    ALUSrcB   = SRCB_RD2;
    ImmSrc    = IMM_I;
    ALUctrl   = ALU_ADD;
    InstrDone = 1'b0;
    Illegal   = 1'b0;

    // Reset forces every output low so an abandoned instruction cannot
    // write anything in the reset cycle.
    if (rst) begin
      state_nxt = S_FETCH;
    end else begin
      ImmSrc = imm_src(op);
      case (state)
        S_FETCH: begin
          MemReq    = 1'b1;
          AdrSrc    = ADR_PC;
          ALUSrcA   = SRCA_PC;
          ALUSrcB   = SRCB_FOUR;
          ResultSrc = RES_ALURESULT;
          if (MemReady) begin
            IRWrite   = 1'b1;
            PCWrite   = 1'b1;
            state_nxt = S_DECODE;
          end
        end
        S_DECODE: begin
          ALUSrcA = SRCA_OLDPC;
          ALUSrcB = SRCB_IMM;
          case (op)
            OP_LW, OP_SW: state_nxt = S_MEMADR;
            OP_R:         state_nxt = S_EXECUTER;
            OP_ADDI:      state_nxt = S_EXECUTEI;
            OP_BEQ:       state_nxt = S_BEQ;
            default: begin
              Illegal   = 1'b1;
              state_nxt = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_IMM;
          state_nxt = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        end
        S_MEMREAD: begin
          MemReq = 1'b1;
          AdrSrc = ADR_ALUOUT;
          if (MemReady) state_nxt = S_MEMWB;
        end
        S_MEMWB: begin
          ResultSrc = RES_READDATA;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          state_nxt = S_FETCH;
        end
        S_MEMWRITE: begin
          MemReq   = 1'b1;
          MemWrite = 1'b1;
          AdrSrc   = ADR_ALUOUT;
          if (MemReady) begin
            InstrDone = 1'b1;
            state_nxt = S_FETCH;
          end
        end
        S_EXECUTER: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_RD2;
          ALUctrl   = alu_dec;
          state_nxt = S_ALUWB;
        end
        S_EXECUTEI: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_IMM;
          ALUctrl   = alu_dec;
          state_nxt = S_ALUWB;
        end
        S_ALUWB: begin
          ResultSrc = RES_ALUOUT;
          RegWrite  = 1'b1;
          InstrDone = 1'b1;
          state_nxt = S_FETCH;
        end
        S_BEQ: begin
          ALUSrcA   = SRCA_RD1;
          ALUSrcB   = SRCB_RD2;
          ALUctrl   = ALU_SUB;
          ResultSrc = RES_ALUOUT;
          PCWrite   = EQ;
          InstrDone = 1'b1;
          state_nxt = S_FETCH;
        end
        default: state_nxt = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench: every cycle the stimulus pushes the hand-computed
// output vector into a queue; the monitor pops and compares on each falling
// edge.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] Instr;
  logic        EQ;
  logic        MemReady;
  logic        MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
  logic [2:0]  ALUctrl;
  logic        InstrDone, Illegal;

  multicycle_control dut (
    .clk       (clk),
    .rst       (rst),
    .Instr     (Instr),
    .EQ        (EQ),
    .MemReady  (MemReady),
    .MemReq    (MemReq),
    .MemWrite  (MemWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .RegWrite  (RegWrite),
    .ResultSrc (ResultSrc),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ImmSrc    (ImmSrc),
    .ALUctrl   (ALUctrl),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  always #5 clk = ~clk;

  logic [18:0] exp_q[$];
  string       name_q[$];
  int          n_checks = 0;
  int          n_pass   = 0;

  localparam logic [31:0] I_ADD  = 32'h002081B3;
  localparam logic [31:0] I_SUB  = 32'h402081B3;
  localparam logic [31:0] I_SLT  = 32'h0020A1B3;
  localparam logic [31:0] I_OR   = 32'h0020E1B3;
  localparam logic [31:0] I_LW   = 32'h0000A183;
  localparam logic [31:0] I_SW   = 32'h0030A023;
  localparam logic [31:0] I_BEQ  = 32'h00208463;
  localparam logic [31:0] I_ILL  = 32'h0000007F;
  localparam logic [31:0] I_ADDI = 32'h40008093;  // addi x1,x1,0x400 (bit 30 set)

  // mreq,mwr,adr,irw,pcw,rw,res,srca,srcb,imm,alu,done,ill
  function automatic logic [18:0] ev(
      input logic mreq, input logic mwr, input logic adr, input logic irw,
      input logic pcw, input logic rw, input logic [1:0] res,
      input logic [1:0] sa, input logic [1:0] sb, input logic [1:0] imm,
      input logic [2:0] alu, input logic done, input logic ill);
    ev = {mreq, mwr, adr, irw, pcw, rw, res, sa, sb, imm, alu, done, ill};
  endfunction

  task automatic cyc(input string nm, input logic [31:0] ins, input logic r,
                     input logic mr, input logic e, input logic [18:0] exp);
    Instr    = ins;
    rst      = r;
    MemReady = mr;
    EQ       = e;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [18:0] act, req;
      string nm;
      req = exp_q.pop_front();
      nm  = name_q.pop_front();
      act = {MemReq, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ResultSrc,
             ALUSrcA, ALUSrcB, ImmSrc, ALUctrl, InstrDone, Illegal};
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: outputs %b, required %b", nm, act, req);
    end
  end

  initial begin
    rst = 1'b1; Instr = '0; EQ = 1'b0; MemReady = 1'b0;
    @(posedge clk);
    #1;

    cyc("reset",       32'h0, 1, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));

    cyc("add_fetch",   32'h0, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("add_decode",  I_ADD, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("add_execr",   I_ADD, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b000,0,0));
    cyc("add_aluwb",   I_ADD, 0, 1, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    cyc("sub_fetch",   I_ADD, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("sub_decode",  I_SUB, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("sub_execr",   I_SUB, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b001,0,0));
    cyc("sub_aluwb",   I_SUB, 0, 1, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    cyc("slt_fetch",   I_SUB, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("slt_decode",  I_SLT, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("slt_execr",   I_SLT, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b101,0,0));
    cyc("slt_aluwb",   I_SLT, 0, 1, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    cyc("lw_fetch",    I_SLT, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("lw_decode",   I_LW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("lw_memadr",   I_LW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("lw_rd_wait1", I_LW,  0, 0, 0, ev(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_rd_wait2", I_LW,  0, 0, 0, ev(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_rd_done",  I_LW,  0, 1, 0, ev(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("lw_memwb",    I_LW,  0, 1, 0, ev(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,3'b000,1,0));

    cyc("sw_fetch",    I_LW,  0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("sw_decode",   I_SW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b01,3'b000,0,0));
    cyc("sw_memadr",   I_SW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b01,3'b000,0,0));
    cyc("sw_memwrite", I_SW,  0, 1, 0, ev(1,1,1,0,0,0,2'b00,2'b00,2'b00,2'b01,3'b000,1,0));

    cyc("beq1_fwait",  I_SW,  0, 0, 0, ev(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("beq1_fetch",  I_SW,  0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b01,3'b000,0,0));
    cyc("beq1_decode", I_BEQ, 0, 1, 1, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    cyc("beq1_taken",  I_BEQ, 0, 1, 1, ev(0,0,0,0,1,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));

    cyc("beq0_fetch",  I_BEQ, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    cyc("beq0_decode", I_BEQ, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b10,3'b000,0,0));
    cyc("beq0_nottkn", I_BEQ, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b001,1,0));

    cyc("ill_fetch",   I_BEQ, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b10,3'b000,0,0));
    cyc("ill_decode",  I_ILL, 0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,1));

    cyc("rst_fetch",   I_ILL, 0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("rst_decode",  I_LW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("rst_memadr",  I_LW,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("rst_memread", I_LW,  1, 0, 0, ev(0,0,0,0,0,0,2'b00,2'b00,2'b00,2'b00,3'b000,0,0));
    cyc("rst_after",   I_LW,  0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));

    cyc("addi_decode", I_ADDI,0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("addi_execi",  I_ADDI,0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,3'b000,0,0));
    cyc("addi_aluwb",  I_ADDI,0, 1, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    cyc("or_fetch",    I_ADDI,0, 1, 0, ev(1,0,0,1,1,0,2'b10,2'b00,2'b10,2'b00,3'b000,0,0));
    cyc("or_decode",   I_OR,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,3'b000,0,0));
    cyc("or_execr",    I_OR,  0, 1, 0, ev(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b00,3'b011,0,0));
    cyc("or_aluwb",    I_OR,  0, 1, 0, ev(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000,1,0));

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      n_checks++;
      $display("FAIL drain: %0d vectors left unchecked, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
